// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - round-robin sequencer for one shared shift-add multiplier
// Optional macro MULT_EARLY_EXIT_EN: leave CALC as soon as the shifted multiplier reaches zero.
module mult_share_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               Clk,
  input  logic               Resetn,
  input  logic               Req0,
  input  logic [WIDTH-1:0]   X0,
  input  logic [WIDTH-1:0]   Y0,
  output logic               Ack0,
  input  logic               Req1,
  input  logic [WIDTH-1:0]   X1,
  input  logic [WIDTH-1:0]   Y1,
  output logic               Ack1,
  output logic               Busy,
  output logic               Done,
  output logic               Owner,
  output logic [2*WIDTH-1:0] M
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2*WIDTH-1:0] r_x;
  logic [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic               r_last;
  logic               r_ack0;
  logic               r_ack1;
  logic               r_busy;
  logic               r_done;
  logic               r_owner;
  logic [2*WIDTH-1:0] r_m;

  logic               w_grant;
  logic               w_grant_ch;
  logic [WIDTH-1:0]   w_x_sel;
  logic [WIDTH-1:0]   w_y_sel;
  logic [WIDTH-1:0]   w_y_shift;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_calc_last;

  assign w_y_shift = r_y >> 1;
  assign w_acc_nxt = r_y[0] ? (r_acc + r_x) : r_acc;

`ifdef MULT_EARLY_EXIT_EN
  assign w_calc_last = (r_count == CW'(WIDTH - 1)) || (w_y_shift == '0);
`else
  assign w_calc_last = (r_count == CW'(WIDTH - 1));
`endif

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_CALC;
      S_CALC:  if (w_calc_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // On a tie the channel that was not served last wins.
  always_comb begin
    w_grant    = 1'b0;
    w_grant_ch = 1'b0;
    if (r_state == S_IDLE) begin
      if (Req0 && Req1) begin
        w_grant    = 1'b1;
        w_grant_ch = ~r_last;
      end else if (Req0) begin
        w_grant    = 1'b1;
        w_grant_ch = 1'b0;
      end else if (Req1) begin
        w_grant    = 1'b1;
        w_grant_ch = 1'b1;
      end
    end
    w_x_sel = w_grant_ch ? X1 : X0;
    w_y_sel = w_grant_ch ? Y1 : Y0;
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      r_x     <= '0;
      r_y     <= '0;
      r_acc   <= '0;
      r_count <= '0;
      r_last  <= 1'b1;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_owner <= 1'b0;
      r_m     <= '0;
    end else begin
      r_ack0 <= w_grant && !w_grant_ch;
      r_ack1 <= w_grant && w_grant_ch;
      r_done <= (r_state == S_CALC) && w_calc_last;
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_grant) begin
        r_x     <= {{WIDTH{1'b0}}, w_x_sel};
        r_y     <= w_y_sel;
        r_acc   <= '0;
        r_count <= '0;
        r_owner <= w_grant_ch;
        r_last  <= w_grant_ch;
      end else if (r_state == S_CALC) begin
        r_acc   <= w_acc_nxt;
        r_x     <= r_x << 1;
        r_y     <= w_y_shift;
        r_count <= r_count + CW'(1);
        if (w_calc_last) r_m <= w_acc_nxt;
      end
    end
  end

  assign Ack0  = r_ack0;
  assign Ack1  = r_ack1;
  assign Busy  = r_busy;
  assign Done  = r_done;
  assign Owner = r_owner;
  assign M     = r_m;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb/tb_mult_share_ctrl.sv - scoreboard bench for mult_share_ctrl (WIDTH=4, either macro setting)
module tb_mult_share_ctrl;

  localparam int WIDTH = 4;

  logic             Clk = 1'b0;
  logic             Resetn = 1'b0;
  logic             Req0 = 1'b0;
  logic [WIDTH-1:0] X0 = '0;
  logic [WIDTH-1:0] Y0 = '0;
  logic             Ack0;
  logic             Req1 = 1'b0;
  logic [WIDTH-1:0] X1 = '0;
  logic [WIDTH-1:0] Y1 = '0;
  logic             Ack1;
  logic             Busy;
  logic             Done;
  logic             Owner;
  logic [2*WIDTH-1:0] M;

  typedef struct {
    logic [2*WIDTH-1:0] m;
    logic               owner;
    int                 lat;
  } sb_t;

  sb_t sb[$];
  int  n_chk = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  acc_cyc = 0;
  logic [2*WIDTH-1:0] m_model = '0;

  mult_share_ctrl #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Resetn(Resetn),
    .Req0(Req0), .X0(X0), .Y0(Y0), .Ack0(Ack0),
    .Req1(Req1), .X1(X1), .Y1(Y1), .Ack1(Ack1),
    .Busy(Busy), .Done(Done), .Owner(Owner), .M(M)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Posedges from the accept edge to the edge that raises Done.
  function automatic int exp_steps(input logic [WIDTH-1:0] y);
    int s;
    s = WIDTH;
`ifdef MULT_EARLY_EXIT_EN
    s = 1;
    for (int i = 0; i < WIDTH; i++) if (y[i]) s = i + 1;
`endif
    return s;
  endfunction

  task automatic push(input logic ch, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    sb_t e;
    e.m     = (2*WIDTH)'(x) * (2*WIDTH)'(y);
    e.owner = ch;
    e.lat   = exp_steps(y);
    sb.push_back(e);
  endtask

  task automatic do_req(input logic ch, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    bit got_ack;
    got_ack = 1'b0;
    if (ch) begin Req1 = 1'b1; X1 = x; Y1 = y; end
    else    begin Req0 = 1'b1; X0 = x; Y0 = y; end
    for (int i = 0; i < 40 && !got_ack; i++) begin
      @(negedge Clk);
      got_ack = ch ? Ack1 : Ack0;
    end
    if (!got_ack) chk(ch ? "ack1_timeout" : "ack0_timeout", 32'd0, 32'd1);
    // Scrambled operands after Ack must not reach the product.
    if (ch) begin Req1 = 1'b0; X1 = ~x; Y1 = ~y; end
    else    begin Req0 = 1'b0; X0 = ~x; Y0 = ~y; end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge Clk);
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge Clk) begin
    sb_t e;
    if (!Resetn) begin
      m_model = '0;
    end else begin
      chk("ack_excl", 32'(Ack0 & Ack1), 32'd0);
      chk("ack_done_excl", 32'((Ack0 | Ack1) & Done), 32'd0);
      if (Ack0 | Ack1) acc_cyc = cyc;
      if (Done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("product", 32'(M), 32'(e.m));
          chk("owner", 32'(Owner), 32'(e.owner));
          chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
          m_model = e.m;
        end
      end else begin
        chk("m_hold", 32'(M), 32'(m_model));
      end
    end
  end

  initial begin
    int n;
    Resetn = 1'b0;
    Req0 = 1'b1; X0 = 4'd3;  Y0 = 4'd5;
    Req1 = 1'b1; X1 = 4'd15; Y1 = 4'd15;
    repeat (2) @(negedge Clk);
    chk("rst_ack0", 32'(Ack0), 32'd0);
    chk("rst_ack1", 32'(Ack1), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_m", 32'(M), 32'd0);
    chk("rst_owner", 32'(Owner), 32'd0);
    Resetn = 1'b1;

    // Tie after reset: ch0 first, then ch1.
    push(1'b0, 4'd3, 4'd5);
    push(1'b1, 4'd15, 4'd15);
    fork
      do_req(1'b0, 4'd3, 4'd5);
      do_req(1'b1, 4'd15, 4'd15);
    join
    drain();

    // Tie again after ch1 was served: ch0 wins; zero operands on both.
    push(1'b0, 4'd0, 4'd9);
    push(1'b1, 4'd9, 4'd0);
    fork
      do_req(1'b0, 4'd0, 4'd9);
      do_req(1'b1, 4'd9, 4'd0);
    join
    drain();

    push(1'b0, 4'd13, 4'd11);
    do_req(1'b0, 4'd13, 4'd11);
    n = 0;
    while (Busy && n < 20) begin
      n++;
      @(negedge Clk);
    end
    chk("busy_len", 32'(n), 32'(exp_steps(4'd11) + 1));
    drain();

    push(1'b1, 4'd15, 4'd15);
    do_req(1'b1, 4'd15, 4'd15);
    drain();
    repeat (8) @(negedge Clk);
    chk("m_hold_gap", 32'(M), 32'd225);

    push(1'b0, 4'd7, 4'd1);
    do_req(1'b0, 4'd7, 4'd1);
    drain();
    push(1'b0, 4'd5, 4'd8);
    do_req(1'b0, 4'd5, 4'd8);
    drain();

    // Abort mid-CALC: no Done may follow, M clears.
    do_req(1'b1, 4'd6, 4'd7);
    repeat (2) @(negedge Clk);
    Resetn = 1'b0;
    repeat (2) @(negedge Clk);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_m", 32'(M), 32'd0);
    Resetn = 1'b1;
    repeat (8) @(negedge Clk);
    push(1'b1, 4'd6, 4'd7);
    do_req(1'b1, 4'd6, 4'd7);
    drain();
    repeat (4) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Two-requester scheduler and sequencer for one shared shift-add multiplier datapath (X shift-left, Y shift-right, accumulate when Y[0]=1).
- Arbitrates between channel 0 and channel 1 with round-robin priority and latches the winner's operands.
- Runs the add/shift steps, then publishes the product with a one-cycle Done pulse tagged with the owning channel.
- Sits between operand producers and the consumers of the product.

Parameters:
- WIDTH, 4, operand width in bits; product width is 2*WIDTH.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Resetn  in  1  synchronous, active-low reset.
- Req0  in  1  channel 0 request; held high until Ack0.
- X0  in  WIDTH  channel 0 multiplicand.
- Y0  in  WIDTH  channel 0 multiplier.
- Ack0  out  1  one-cycle pulse; channel 0 operands accepted.
- Req1  in  1  channel 1 request; held high until Ack1.
- X1  in  WIDTH  channel 1 multiplicand.
- Y1  in  WIDTH  channel 1 multiplier.
- Ack1  out  1  one-cycle pulse; channel 1 operands accepted.
- Busy  out  1  high while a multiply is in progress (states CALC and DONE).
- Done  out  1  one-cycle pulse; M and Owner valid.
- Owner  out  1  channel that owns the current or most recent result.
- M  out  2*WIDTH  product register; holds its value until the next Done.

Behaviour:
- All outputs and state are registered. Reset is synchronous on the Clk edge when Resetn=0.
- Reset values: state=IDLE, Ack0=Ack1=0, Busy=0, Done=0, Owner=0, M=0, accumulator=0, step count=0, last-served=1 (channel 0 wins first tie).
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If neither Req is high, stay in IDLE.
  - If exactly one Req is high, grant that channel.
  - If both are high, grant the channel that is not last-served.
  - On a grant edge: Xreg={0,Xn} (2*WIDTH bits), Yreg=Yn, acc=0, count=0, Owner=n, last-served=n, pulse Ackn high for the following cycle, go to CALC.
- CALC, one step per cycle:
  - If Yreg[0]=1, acc<=acc+Xreg (2*WIDTH bits, no overflow possible); otherwise acc is unchanged.
  - Xreg<<=1, Yreg>>=1, count++.
  - After WIDTH steps (count==WIDTH-1 at the edge), go to DONE and load M<=final acc.
- DONE: Done=1 for exactly this one cycle, Busy=1, then return to IDLE. No grant is issued in DONE.
- Latency: accept edge at T; CALC occupies cycles T+1..T+WIDTH; Done is high in cycle T+WIDTH+1.
  - Earliest next accept is the edge ending cycle T+WIDTH+2 (IDLE).
  - Throughput is one multiply per WIDTH+2 cycles.
- Requests made while Busy stay pending; the requester holds Req and operands.
  - Operands are sampled only on the grant edge.
  - Changes to Xn/Yn after Ack have no effect.
- A request dropped before it is granted is ignored; no Ack is issued.
- Ack0 and Ack1 are never high together. Ack and Done are never high in the same cycle.
- Owner changes only on a grant edge; M changes only on entry to DONE.
- Reset mid-operation: everything returns to reset values immediately. No Done is produced for the aborted operation and M=0.
- Zero operands follow the normal path: full latency, result 0.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined: CALC also exits to DONE at the edge where the shifted Yreg becomes 0, even if count<WIDTH-1.
  - CALC still lasts at least 1 cycle.
  - Done/M/Owner rules are unchanged; latency is variable (2..WIDTH+1 cycles from accept edge to Done).
- Undefined: fixed WIDTH-cycle CALC as specified above.

Test Plan:
- Reset: Resetn=0 for 2 cycles with both Req high -> Ack0=Ack1=Busy=Done=0, M=0, Owner=0. After release, channel 0 is granted first.
- Single request: Req0, X0=13, Y0=11.
  - Ack0 pulses in the cycle after the accept edge.
  - Done pulses 5 cycles after the accept edge (macro off) with M=143, Owner=0.
  - Busy is high for exactly 5 cycles.
- Round-robin, WIDTH=4:
  - Req0 (3x5) and Req1 (15x15) held high together -> ch0 first (M=15, Owner=0), then ch1 (M=225, Owner=1).
  - Both asserted again -> ch0 granted next.
- Boundaries: 15x15 -> M=225; 0x9 -> M=0 with full latency; 9x0 -> M=0.
  - M holds 225 across the idle gap until the next Done.
- Reset mid-CALC:
  - Assert Resetn=0 two cycles after Ack1 -> no Done, M=0, Busy=0.
  - Then Req1 with 6x7 -> M=42, Owner=1.
- Macro MULT_EARLY_EXIT_EN defined:
  - X0=7, Y0=1 -> Done 2 cycles after the accept edge, M=7.
  - X0=5, Y0=8 -> Done 5 cycles after the accept edge, M=40.
  - With the macro undefined, both cases take 5 cycles.
